// File: rtl/det_event_counter.sv
// Windowed rising-edge counter for the Moore/Mealy detector flag pair.
// Counts both edges over WIN_LEN cycles, then freezes counts and flags disagreement.
module det_event_counter #(
    parameter int CNT_W   = 16,
    parameter int WIN_LEN = 10000
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             start,
    input  logic             moore_in,
    input  logic             mealy_in,
    output logic [CNT_W-1:0] cnt_moore,
    output logic [CNT_W-1:0] cnt_mealy,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [23:0] WIN_INIT = 24'(WIN_LEN - 1);

    state_t           state_q, state_d;
    logic             moore_prev, mealy_prev;
    logic [23:0]      win_q, win_d;
    logic [CNT_W-1:0] moore_q, moore_d;
    logic [CNT_W-1:0] mealy_q, mealy_d;
    logic             mism_q, mism_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             rise_moore, rise_mealy;
    logic             sat_moore, sat_mealy;
    logic [CNT_W-1:0] moore_inc, mealy_inc;

    assign rise_moore = moore_in & ~moore_prev;
    assign rise_mealy = mealy_in & ~mealy_prev;
    assign sat_moore  = &moore_q;
    assign sat_mealy  = &mealy_q;

    // Saturating increments; a rise at all-ones holds the count.
    assign moore_inc = (rise_moore && !sat_moore) ? moore_q + CNT_W'(1) : moore_q;
    assign mealy_inc = (rise_mealy && !sat_mealy) ? mealy_q + CNT_W'(1) : mealy_q;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q    <= IDLE;
            moore_prev <= 1'b0;
            mealy_prev <= 1'b0;
            win_q      <= '0;
            moore_q    <= '0;
            mealy_q    <= '0;
            mism_q     <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            moore_prev <= moore_in;
            mealy_prev <= mealy_in;
            win_q      <= win_d;
            moore_q    <= moore_d;
            mealy_q    <= mealy_d;
            mism_q     <= mism_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        moore_d = moore_q;
        mealy_d = mealy_q;
        mism_d  = mism_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    win_d   = WIN_INIT;
                    moore_d = '0;
                    mealy_d = '0;
                    mism_d  = 1'b0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                moore_d = moore_inc;
                mealy_d = mealy_inc;
                ovf_d   = ovf_q | (rise_moore & sat_moore) | (rise_mealy & sat_mealy);
                if (win_q != 24'd0) begin
                    win_d = win_q - 24'd1;
                end else begin
                    // Last sample: compare the post-increment counts.
                    state_d = DONE;
                    mism_d  = (moore_inc != mealy_inc);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cnt_moore = moore_q;
    assign cnt_mealy = mealy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mismatch  = mism_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_det_event_counter.sv
// Directed bench for det_event_counter with a result scoreboard.
// Two instances: WIN_LEN=10/CNT_W=16 and WIN_LEN=30/CNT_W=3 (saturation).
module tb_det_event_counter;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic        moore_in = 1'b0;
    logic        mealy_in = 1'b0;

    logic [15:0] cm, ca;
    logic        busy, done, mism, ovf;
    logic [2:0]  cm_s, ca_s;
    logic        busy_s, done_s, mism_s, ovf_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] moore;
        logic [15:0] mealy;
        logic        mism;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    det_event_counter #(.CNT_W(16), .WIN_LEN(10)) dut (
        .clk(clk), .res_n(res_n), .start(start),
        .moore_in(moore_in), .mealy_in(mealy_in),
        .cnt_moore(cm), .cnt_mealy(ca), .busy(busy), .done(done),
        .mismatch(mism), .overflow(ovf)
    );

    det_event_counter #(.CNT_W(3), .WIN_LEN(30)) dut_s (
        .clk(clk), .res_n(res_n), .start(start_s),
        .moore_in(moore_in), .mealy_in(mealy_in),
        .cnt_moore(cm_s), .cnt_mealy(ca_s), .busy(busy_s), .done(done_s),
        .mismatch(mism_s), .overflow(ovf_s)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] o_moore(input bit sm);
        return sm ? {13'b0, cm_s} : cm;
    endfunction
    function automatic logic [15:0] o_mealy(input bit sm);
        return sm ? {13'b0, ca_s} : ca;
    endfunction
    function automatic logic o_busy(input bit sm);
        return sm ? busy_s : busy;
    endfunction
    function automatic logic o_done(input bit sm);
        return sm ? done_s : done;
    endfunction

    // Bit 0 of mo/me is the input level at the start edge S; bit i is sample i (edge S+i).
    task automatic run_win(input string tag, input int n, input logic [39:0] mo,
                           input logic [39:0] me, input logic [39:0] st, input bit sm,
                           input logic [15:0] em, input logic [15:0] ea,
                           input logic emm, input logic eov);
        exp_t e;
        sb.push_back('{tag, em, ea, emm, eov});
        moore_in = mo[0];
        mealy_in = me[0];
        if (sm) start_s = 1'b1;
        else start = 1'b1;
        step();
        start = 1'b0;
        start_s = 1'b0;
        chk({tag, " busy@S"}, 32'(o_busy(sm)), 32'd1);
        chk({tag, " done@S"}, 32'(o_done(sm)), 32'd0);
        chk({tag, " cnt_moore@S"}, 32'(o_moore(sm)), 32'd0);
        chk({tag, " cnt_mealy@S"}, 32'(o_mealy(sm)), 32'd0);
        for (int i = 1; i <= n; i++) begin
            moore_in = mo[i];
            mealy_in = me[i];
            if (sm) start_s = st[i];
            else start = st[i];
            step();
            if (i == n - 1) chk({tag, " done early"}, 32'(o_done(sm)), 32'd0);
        end
        start = 1'b0;
        start_s = 1'b0;
        chk({tag, " done"}, 32'(o_done(sm)), 32'd1);
        chk({tag, " busy end"}, 32'(o_busy(sm)), 32'd0);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({e.tag, " cnt_moore"}, 32'(o_moore(sm)), 32'(e.moore));
            chk({e.tag, " cnt_mealy"}, 32'(o_mealy(sm)), 32'(e.mealy));
            chk({e.tag, " mismatch"}, 32'(sm ? mism_s : mism), 32'(e.mism));
            chk({e.tag, " overflow"}, 32'(sm ? ovf_s : ovf), 32'(e.ovf));
        end
    endtask

    logic [39:0] v;

    initial begin
        // Reset with toggling inputs
        res_n = 1'b0;
        start = 1'b1;
        start_s = 1'b1;
        moore_in = 1'b1;
        mealy_in = 1'b0;
        step();
        start = 1'b0;
        start_s = 1'b0;
        moore_in = 1'b0;
        mealy_in = 1'b1;
        step();
        chk("rst outs", {cm, ca}, 32'd0);
        chk("rst flags", {28'd0, busy, done, mism, ovf}, 32'd0);
        chk("rst small", {22'd0, cm_s, ca_s, busy_s, done_s, mism_s, ovf_s}, 32'd0);
        res_n = 1'b1;
        mealy_in = 1'b0;
        step();
        step();
        chk("idle hold", {30'd0, busy, done}, 32'd0);

        // Basic count
        run_win("basic", 10, (40'd1 << 3) | (40'd1 << 6),
                (40'd1 << 2) | (40'd1 << 5), 40'd0, 1'b0, 16'd2, 16'd2, 1'b0, 1'b0);

        // Moore held high across the whole window
        moore_in = 1'b1;
        step();
        run_win("prehigh", 10, '1, 40'd0, 40'd0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);

        // Moore drops at sample 4, rises at sample 6
        run_win("refall", 10, ~((40'd1 << 4) | (40'd1 << 5)), 40'd0, 40'd0, 1'b0,
                16'd1, 16'd0, 1'b1, 1'b0);

        // Saturation on the 3-bit instance
        v = '0;
        for (int i = 0; i < 9; i++) v[2*i+1] = 1'b1;
        run_win("sat", 30, 40'd0, v, 40'd0, 1'b1, 16'd0, 16'd7, 1'b1, 1'b1);

        // Mealy at last sample, Moore just after the window
        run_win("boundary", 10, 40'd0, 40'd1 << 10, 40'd0, 1'b0, 16'd0, 16'd1, 1'b1, 1'b0);
        moore_in = 1'b1;
        mealy_in = 1'b0;
        step();
        chk("boundary hold moore", 32'(cm), 32'd0);
        chk("boundary hold done", 32'(done), 32'd1);
        moore_in = 1'b0;
        step();

        // Start pulse mid-RUN is ignored
        run_win("midstart", 10, 40'd1 << 7, 40'd1 << 6, 40'd1 << 5, 1'b0,
                16'd1, 16'd1, 1'b0, 1'b0);

        // Reset mid-RUN, start held high during reset
        start = 1'b1;
        step();
        start = 1'b0;
        mealy_in = 1'b1;
        moore_in = 1'b1;
        step();
        chk("midrst running", 32'(ca), 32'd1);
        mealy_in = 1'b0;
        moore_in = 1'b0;
        step();
        res_n = 1'b0;
        start = 1'b1;
        step();
        chk("midrst cnts", {cm, ca}, 32'd0);
        chk("midrst flags", {28'd0, busy, done, mism, ovf}, 32'd0);
        res_n = 1'b1;
        start = 1'b0;
        step();
        chk("midrst idle", {30'd0, busy, done}, 32'd0);

        // Clean window after reset; simultaneous rises
        run_win("postrst", 10, (40'd1 << 1) | (40'd1 << 8), 40'd1 << 1, 40'd0, 1'b0,
                16'd2, 16'd1, 1'b1, 1'b0);

        // Start from DONE clears and relaunches (checked at S inside run_win)
        run_win("fromdone", 10, 40'd1 << 4, 40'd1 << 3, 40'd0, 1'b0,
                16'd1, 16'd1, 1'b0, 1'b0);

        chk("sb drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/det_event_counter.md
# det_event_counter

Windowed event counter that sits directly downstream of the overlapped-sequence detector pair. It consumes the Moore flag and the Mealy flag and counts rising edges of each over a fixed window of clock cycles. At window end it freezes both counts and reports whether they agree. It replaces bench-side posedge counting with a synthesizable statistics stage.

## Interface
- `CNT_W`, default 16: width of each event counter.
- `WIN_LEN`, default 10000: window length in clock cycles; legal range is 1 to 2^24-1.

- `clk`, in, 1: the single clock; all logic on its rising edge.
- `res_n`, in, 1: reset, synchronous and active-low.
- `start`, in, 1: window start request, sampled each cycle.
- `moore_in`, in, 1: Moore detector flag (F0).
- `mealy_in`, in, 1: Mealy detector flag (F1).
- `cnt_moore`, out, CNT_W: Moore rising-edge count.
- `cnt_mealy`, out, CNT_W: Mealy rising-edge count.
- `busy`, out, 1: high while a window is running.
- `done`, out, 1: high while results are frozen and valid.
- `mismatch`, out, 1: counts differ at window end; valid when `done`=1.
- `overflow`, out, 1: sticky; a counter saturated during the window.

## Operation
- States are IDLE, RUN and DONE. All outputs are registered.
- Edge detect:
  - `moore_prev` and `mealy_prev` register the inputs every cycle, in every state.
  - `rise_x = x_in & ~x_prev`.
  - An input already high when a window opens does not count until it falls and rises again.
- IDLE:
  - `start`=1 clears both counts, `mismatch` and `overflow`.
  - It loads `win_cnt` = WIN_LEN-1 and moves to RUN.
- RUN:
  - On each edge, for each input with `rise_x`=1, increment its count.
  - A count at all-ones does not wrap. It holds and sets `overflow`.
  - If `win_cnt`≠0, decrement it.
  - If `win_cnt`=0, this sample is still counted. Go to DONE.
  - On the same edge, register `mismatch` = (final Moore count ≠ final Mealy count), using the post-increment values.
  - `start` is ignored in RUN; the window is not restarted.
- DONE:
  - Counts, `mismatch` and `overflow` hold.
  - `start`=1 behaves exactly as in IDLE (clear, load, RUN).
- The Mealy flag normally leads Moore by one cycle. A Mealy rise in the last window cycle whose Moore rise lands after the window therefore yields `mismatch`=1. This is intended; window placement is the user's responsibility.
- Arithmetic is unsigned. `win_cnt` is 24 bits.

## Timing
- Reset (`res_n`=0 at an edge):
  - State goes to IDLE.
  - All outputs go to 0.
  - `moore_prev`, `mealy_prev` and `win_cnt` go to 0.
  - Reset takes priority over `start` and aborts a running window, leaving no partial results.
- Window timing, with `start` sampled at edge S:
  - `busy`=1 after S.
  - Samples at edges S+1 through S+WIN_LEN are counted.
  - At edge S+WIN_LEN, `busy` goes to 0 and `done`, `mismatch` and `overflow` become valid together.
- A rise seen at edge k is visible on the count output after edge k (one-cycle latency).
- Simultaneous Moore and Mealy rises in one cycle increment both counters.
- With WIN_LEN=1, exactly one sample (edge S+1) is counted.
- `start` held high continuously: each DONE lasts one cycle, then a new window begins.

## Test plan
- Reset:
  - Stimulus: `res_n`=0 for 2 cycles while `start`, `moore_in` and `mealy_in` toggle.
  - Required: all outputs 0; after release with `start`=0, state stays IDLE (`busy`=0, `done`=0).
- Basic count, WIN_LEN=10, CNT_W=16:
  - Stimulus: `start` pulse. Mealy 1-cycle pulses at window samples 2 and 5; Moore pulses at samples 3 and 6.
  - Required: `done`=1 at edge S+10, `cnt_moore`=2, `cnt_mealy`=2, `mismatch`=0, `overflow`=0.
- Level and pre-high input:
  - Stimulus: `moore_in` high before `start` and held high for the whole window.
  - Required: `cnt_moore`=0.
  - Stimulus: `moore_in` drops at sample 4 and rises at sample 6.
  - Required: `cnt_moore`=1.
- Saturation, CNT_W=3, WIN_LEN=30:
  - Stimulus: 9 Mealy rises.
  - Required: `cnt_mealy`=7, `overflow`=1, `mismatch`=1 (with `cnt_moore`=0).
- Boundary mismatch, WIN_LEN=10:
  - Stimulus: Mealy rise at sample 10, Moore rise at sample 11.
  - Required: `cnt_mealy`=1, `cnt_moore`=0, `mismatch`=1.
- Control corner cases:
  - Stimulus: `start` pulsed mid-RUN.
  - Required: ignored; `done` occurs at the original S+WIN_LEN.
  - Stimulus: `res_n`=0 mid-RUN.
  - Required: outputs 0 after that edge; a subsequent `start` produces a clean full window.
  - Stimulus: `start` issued in DONE.
  - Required: counts cleared, `done` goes to 0 and `busy` to 1 after that edge.
